// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_pkg
//  Description : Shared types and frame-geometry helpers for the multi-channel
//                I2S / left-justified serializer.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2s_pkg;

    // Serial format selector as presented on the mode input
    typedef enum logic {
        I2S_MODE_PHILIPS = 1'b0,
        I2S_MODE_LJ      = 1'b1
    } i2s_mode_t;

    // Nominal DAC master clock
    localparam int c_ref_mclk_hz = 12_288_000;

    // Bit-clock periods in one complete frame
    function automatic int i2s_frame_sclks(input int num_channels, input int slot_width);
        return num_channels * slot_width;
    endfunction

    // Master-clock cycles in one complete frame
    function automatic int i2s_mclk_per_frame(input int num_channels, input int slot_width,
                                              input int mclk_per_sclk);
        return i2s_frame_sclks(num_channels, slot_width) * mclk_per_sclk;
    endfunction

    // Frame geometry of the default configuration (2 x 32-bit slots, 4 clk per sclk)
    localparam int c_default_frame_sclks    = i2s_frame_sclks(2, 32);
    localparam int c_default_mclk_per_frame = i2s_mclk_per_frame(2, 32, 4);
    localparam int c_default_fs_hz          = c_ref_mclk_hz / c_default_mclk_per_frame;

endpackage : i2s_pkg
`default_nettype wire

// File: rtl/i2s_sclk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_sclk_gen
//  Description : Divides the master clock down to the serial bit clock and
//                flags the master-clock cycle that ends each sclk period.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_sclk_gen #(
    parameter int MCLK_PER_SCLK = 4
) (
    input  logic clk,
    input  logic reset,
    output logic o_sclk,
    output logic o_fall
);

    localparam int c_div_w = (MCLK_PER_SCLK > 2) ? $clog2(MCLK_PER_SCLK) : 1;
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(MCLK_PER_SCLK - 1);
    localparam logic [c_div_w-1:0] c_div_half = c_div_w'(MCLK_PER_SCLK / 2);

    logic [c_div_w-1:0] r_div_q;
    logic [c_div_w-1:0] w_div_d;
    logic               r_sclk_q;
    logic               w_sclk_d;

    // Wrap the divider and derive sclk from the value it is about to take, so
    // sclk falls in the same cycle the divider returns to zero
    always_comb begin
        w_div_d  = (r_div_q == c_div_last) ? '0 : r_div_q + 1'b1;
        w_sclk_d = (w_div_d >= c_div_half);
    end

    // Divider and bit-clock registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_q  <= '0;
            r_sclk_q <= 1'b0;
        end else begin
            r_div_q  <= w_div_d;
            r_sclk_q <= w_sclk_d;
        end
    end

    assign o_sclk = r_sclk_q;
    assign o_fall = (r_div_q == c_div_last);

endmodule : i2s_sclk_gen
`default_nettype wire

// File: rtl/i2s_multi_tx.sv
`default_nettype none
// ============================================================================
//  Module      : i2s_multi_tx
//  Description : Parametrised multi-channel I2S / left-justified serializer
//                with a one-frame holding register and underrun reporting.
//                Build option I2S_UNDERRUN_REPEAT_EN: replay the last frame on
//                underrun instead of sending silence.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2s_multi_tx
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH  = 16,
    parameter int NUM_CHANNELS  = 2,
    parameter int SLOT_WIDTH    = 32,
    parameter int MCLK_PER_SCLK = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 mode,
    input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] s_data,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    output logic                                 i2s_sclk,
    output logic                                 i2s_ws,
    output logic                                 i2s_sd,
    output logic                                 frame_start,
    output logic                                 underrun
);

    localparam int c_frame_sclks = i2s_frame_sclks(NUM_CHANNELS, SLOT_WIDTH);
    localparam int c_frame_w     = NUM_CHANNELS * SAMPLE_WIDTH;
    localparam int c_cnt_w       = $clog2(c_frame_sclks);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(c_frame_sclks - 1);
    localparam logic [c_cnt_w-1:0] c_half_bit = c_cnt_w'(c_frame_sclks / 2);

    // Lay the packed samples out as a slot-padded serial image, channel 0
    // first, each sample MSB-first at the top of its slot
    function automatic logic [c_frame_sclks-1:0] expand_frame(input logic [c_frame_w-1:0] f);
        logic [c_frame_sclks-1:0] img;
        img = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            img[c_frame_sclks-1-k*SLOT_WIDTH -: SAMPLE_WIDTH] = f[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
        return img;
    endfunction

    logic                     w_fall;
    logic                     w_boundary;
    logic                     w_accept;

    logic [c_cnt_w-1:0]       r_bit_cnt_q, w_bit_cnt_d;
    logic [c_frame_sclks-1:0] r_shift_q,   w_shift_d;
    logic [c_frame_w-1:0]     r_hold_q,    w_hold_d;
    logic                     r_hold_full_q, w_hold_full_d;
    logic                     r_armed_q,   w_armed_d;
    i2s_mode_t                r_mode_q,    w_mode_d;
    logic                     r_delay_q,   w_delay_d;
    logic                     r_sd_q,      w_sd_d;
    logic                     r_ws_q,      w_ws_d;
    logic                     r_frame_start_q, w_frame_start_d;
    logic                     r_underrun_q,    w_underrun_d;
`ifdef I2S_UNDERRUN_REPEAT_EN
    logic [c_frame_w-1:0]     r_last_q,    w_last_d;
`endif

    i2s_sclk_gen #(
        .MCLK_PER_SCLK (MCLK_PER_SCLK)
    ) u_sclk_gen (
        .clk    (clk),
        .reset  (reset),
        .o_sclk (i2s_sclk),
        .o_fall (w_fall)
    );

    assign w_boundary = w_fall && (r_bit_cnt_q == c_last_bit);
    assign w_accept   = s_valid && !r_hold_full_q;

    // Handshake, frame-boundary reload and per-bit serialization
    always_comb begin
        w_bit_cnt_d     = r_bit_cnt_q;
        w_shift_d       = r_shift_q;
        w_hold_d        = r_hold_q;
        w_hold_full_d   = r_hold_full_q;
        w_armed_d       = r_armed_q;
        w_mode_d        = r_mode_q;
        w_delay_d       = r_delay_q;
        w_sd_d          = r_sd_q;
        w_ws_d          = r_ws_q;
        w_frame_start_d = 1'b0;
        w_underrun_d    = 1'b0;
`ifdef I2S_UNDERRUN_REPEAT_EN
        w_last_d        = r_last_q;
`endif

        // Accept only into an empty hold; never bypasses into the current
        // boundary, so a same-cycle accept plays one frame later
        if (w_accept) begin
            w_hold_d      = s_data;
            w_hold_full_d = 1'b1;
            w_armed_d     = 1'b1;
        end

        if (w_fall) begin
            if (w_boundary) begin
                w_bit_cnt_d     = '0;
                w_frame_start_d = 1'b1;
                if (r_hold_full_q) begin
                    w_shift_d     = expand_frame(r_hold_q);
                    w_hold_full_d = 1'b0;
                    w_mode_d      = i2s_mode_t'(mode);
`ifdef I2S_UNDERRUN_REPEAT_EN
                    w_last_d      = r_hold_q;
`endif
                end else begin
`ifdef I2S_UNDERRUN_REPEAT_EN
                    w_shift_d     = expand_frame(r_last_q);
`else
                    w_shift_d     = '0;
`endif
                    w_underrun_d  = r_armed_q;
                end
            end else begin
                w_bit_cnt_d = r_bit_cnt_q + 1'b1;
                w_shift_d   = r_shift_q << 1;
            end

            // The delay stage always tracks the undelayed stream so a format
            // switch at a boundary carries the previous frame's last bit
            w_delay_d = w_shift_d[c_frame_sclks-1];
            if (w_mode_d == I2S_MODE_LJ) begin
                w_sd_d = w_shift_d[c_frame_sclks-1];
                w_ws_d = (w_bit_cnt_d < c_half_bit);
            end else begin
                w_sd_d = r_delay_q;
                w_ws_d = (w_bit_cnt_d >= c_half_bit);
            end
        end
    end

    // Serializer state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt_q     <= '0;
            r_shift_q       <= '0;
            r_hold_q        <= '0;
            r_hold_full_q   <= 1'b0;
            r_armed_q       <= 1'b0;
            r_mode_q        <= I2S_MODE_PHILIPS;
            r_delay_q       <= 1'b0;
            r_sd_q          <= 1'b0;
            r_ws_q          <= 1'b0;
            r_frame_start_q <= 1'b0;
            r_underrun_q    <= 1'b0;
        end else begin
            r_bit_cnt_q     <= w_bit_cnt_d;
            r_shift_q       <= w_shift_d;
            r_hold_q        <= w_hold_d;
            r_hold_full_q   <= w_hold_full_d;
            r_armed_q       <= w_armed_d;
            r_mode_q        <= w_mode_d;
            r_delay_q       <= w_delay_d;
            r_sd_q          <= w_sd_d;
            r_ws_q          <= w_ws_d;
            r_frame_start_q <= w_frame_start_d;
            r_underrun_q    <= w_underrun_d;
        end
    end

`ifdef I2S_UNDERRUN_REPEAT_EN
    // Copy of the most recently loaded frame, replayed on underrun
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_q <= '0;
        end else begin
            r_last_q <= w_last_d;
        end
    end
`endif

    assign s_ready     = !r_hold_full_q;
    assign i2s_ws      = r_ws_q;
    assign i2s_sd      = r_sd_q;
    assign frame_start = r_frame_start_q;
    assign underrun    = r_underrun_q;

endmodule : i2s_multi_tx
`default_nettype wire
